vector_lsu: RTL and testbench
=============================

VECTOR_LSU -- requirements
Module: vector_lsu

Interface
REQ-001 The block SHALL have parameter LANES, default 16, meaning the number of vector elements; legal values are 2..64.
REQ-002 The block SHALL have parameter LANE_W, default 8, meaning the element width in bits and the memory port width.
REQ-003 The block SHALL have parameter ADDR_W, default 16, meaning the memory address width.
REQ-004 The block SHALL have ports: clk  in  1  clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-005 The block SHALL have request ports: req_valid in 1; req_ready out 1; req_write in 1 (1=store, 0=load); req_addr in ADDR_W base address; req_wdata in LANES*LANE_W store vector, lane i at bits [i*LANE_W +: LANE_W].
REQ-006 The block SHALL have response ports: resp_valid out 1 completion pulse; resp_rdata out LANES*LANE_W load vector; stall out 1 pipeline freeze.
REQ-007 The block SHALL have memory ports: mem_addr out ADDR_W; mem_wren out 1; mem_wdata out LANE_W; mem_rdata in LANE_W, valid one cycle after mem_addr (synchronous RAM).
REQ-008 When VLSU_STRIDE_EN is defined, the block SHALL have req_stride in ADDR_W, the element spacing in addresses.

Function
REQ-009 The FSM SHALL have states IDLE, ACCESS, DRAIN and DONE.
REQ-010 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on a rising edge with req_valid and req_ready both high (edge T).
REQ-011 On acceptance, the block SHALL latch req_write, req_addr, req_wdata (and req_stride) and enter ACCESS with lane counter = 0.
REQ-012 In ACCESS, each cycle SHALL drive mem_addr = base + lane*step modulo 2^ADDR_W, where step = 1, or req_stride with VLSU_STRIDE_EN; the lane counter SHALL increment each cycle.
REQ-013 For stores in ACCESS, the block SHALL drive mem_wren = 1 and mem_wdata = latched lane; in all other states and for loads, mem_wren SHALL be 0.
REQ-014 ACCESS SHALL last exactly LANES cycles (T+1..T+LANES) and then go to DRAIN for a load or DONE for a store.
REQ-015 For loads, mem_rdata SHALL be captured into lane k of resp_rdata on the edge ending the cycle after lane k's address; DRAIN SHALL last 1 cycle to capture the last lane.
REQ-016 DONE SHALL last 1 cycle with resp_valid = 1, then return to IDLE; resp_valid SHALL be 0 in all other states.
REQ-017 resp_valid SHALL be high in cycle T+LANES+1 for stores and T+LANES+2 for loads.
REQ-018 resp_rdata SHALL hold its value until the next load's first capture; stores SHALL NOT modify it.
REQ-019 stall SHALL be 1 whenever state != IDLE, including DONE.
REQ-020 Address arithmetic SHALL wrap modulo 2^ADDR_W with no error indication.
REQ-021 req_valid SHALL be ignored outside IDLE; the latched request SHALL NOT change mid-operation.
REQ-022 req_ready SHALL be 0 in DONE; a request held through DONE SHALL be accepted on the first IDLE edge.

Reset
REQ-023 While reset is asserted, the block SHALL be in IDLE with the lane counter and latched fields cleared, req_ready = 1 and stall = resp_valid = mem_wren = 0.
REQ-024 While reset is asserted, mem_addr, mem_wdata and resp_rdata SHALL be 0.
REQ-025 Reset mid-operation SHALL abort immediately with no further mem_wren pulses; completed writes SHALL NOT be rolled back.

Configuration
REQ-026 With VLSU_STRIDE_EN defined, the block SHALL provide the req_stride port and step SHALL equal the latched stride; a stride of 0 SHALL repeat one address and is legal.
REQ-027 Without VLSU_STRIDE_EN, the req_stride port SHALL be absent and step SHALL be fixed at 1.

Structure
REQ-028 Package vlsu_pkg SHALL hold the state enum (vlsu_state_t) and the default-parameter constants.
REQ-029 The address generator (base plus lane*step accumulator) SHALL be a single sub-module, vlsu_addr_gen, with no other sub-modules.

Verification (LANES=16, LANE_W=8, ADDR_W=16)
REQ-030 Store of wdata lane i = i+1 to addr 0x0100 -> mem_wren high for 16 cycles at 0x0100..0x010F with data 0x01..0x10, resp_valid at T+17, stall high T+1..T+17.
REQ-031 Load from 0x0100 with a model RAM preloaded as above -> resp_rdata lane i = i+1 and resp_valid at T+18.
REQ-032 Load from base 0xFFF8 -> addresses 0xFFF8..0xFFFF then 0x0000..0x0007, with no error.
REQ-033 With VLSU_STRIDE_EN, a store with stride 4 from 0x0000 -> addresses 0x0000, 0x0004, ..., 0x003C.
REQ-034 Reset asserted at T+5 of a store -> exactly 4 writes occur (0x0100..0x0103), outputs are at reset values immediately, and the next request after reset runs a normal full sequence.
REQ-035 req_valid held high continuously for back-to-back loads -> second acceptance at T+19 with req_ready low T+1..T+18.

Source files
------------

// File: rtl/vlsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vlsu_pkg
// Description : Shared state encoding and default geometry for vector_lsu.
// Revision    : 1.0
// ============================================================================
package vlsu_pkg;

    localparam int VLSU_LANES_DEFAULT  = 16;
    localparam int VLSU_LANE_W_DEFAULT = 8;
    localparam int VLSU_ADDR_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } vlsu_state_t;

endpackage
`default_nettype wire

// File: rtl/vlsu_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : vlsu_addr_gen
// Description : Element address accumulator: base on load, +step per advance.
// Revision    : 1.0
// ============================================================================
module vlsu_addr_gen #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] step,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] r_acc;

    // Sum truncates naturally, giving modulo-2^ADDR_W wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (load) begin
            r_acc <= base;
        end else if (advance) begin
            r_acc <= r_acc + step;
        end
    end

    assign addr = r_acc;

endmodule
`default_nettype wire

// File: rtl/vector_lsu.sv
`default_nettype none
// ============================================================================
// Module      : vector_lsu
// Description : Serialises a LANES-wide vector load/store onto a one-element
//               synchronous memory port. Optional macro: VLSU_STRIDE_EN.
// Revision    : 1.0
// ============================================================================
module vector_lsu
    import vlsu_pkg::*;
#(
    parameter int LANES  = VLSU_LANES_DEFAULT,
    parameter int LANE_W = VLSU_LANE_W_DEFAULT,
    parameter int ADDR_W = VLSU_ADDR_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [LANES*LANE_W-1:0] req_wdata,
`ifdef VLSU_STRIDE_EN
    input  logic [ADDR_W-1:0]       req_stride,
`endif
    output logic                    resp_valid,
    output logic [LANES*LANE_W-1:0] resp_rdata,
    output logic                    stall,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_wren,
    output logic [LANE_W-1:0]       mem_wdata,
    input  logic [LANE_W-1:0]       mem_rdata
);

    localparam int CNT_W = $clog2(LANES + 1);
    localparam int IDX_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    vlsu_state_t             r_state;
    vlsu_state_t             w_next;
    logic [CNT_W-1:0]        r_lane;
    logic                    r_write;
    logic [LANES*LANE_W-1:0] r_wdata;
    logic [LANE_W-1:0]       r_rlanes [LANES];
    logic [LANE_W-1:0]       w_wlanes [LANES];
    logic                    w_accept;
    logic                    w_in_access;
    logic                    w_capture;
    logic [IDX_W-1:0]        w_wr_idx;
    logic [IDX_W-1:0]        w_cap_idx;
    logic [ADDR_W-1:0]       w_step;
    logic [ADDR_W-1:0]       w_gen_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = ACCESS;
            ACCESS:  if (r_lane == LAST_LANE) w_next = r_write ? DONE : DRAIN;
            DRAIN:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_accept    = (r_state == IDLE) && req_valid;
    assign w_in_access = (r_state == ACCESS);
    assign w_wr_idx    = r_lane[IDX_W-1:0];
    assign w_cap_idx   = IDX_W'(r_lane - CNT_W'(1));

    // Read data trails its address by one cycle, so the capture targets the
    // previous lane; DRAIN exists only to collect the final lane.
    assign w_capture = !r_write &&
                       ((w_in_access && (r_lane != '0)) || (r_state == DRAIN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lane  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_rlanes[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_lane  <= '0;
                r_write <= req_write;
                r_wdata <= req_wdata;
            end else if (w_in_access) begin
                r_lane <= r_lane + CNT_W'(1);
            end
            if (w_capture) begin
                r_rlanes[w_cap_idx] <= mem_rdata;
            end
        end
    end

`ifdef VLSU_STRIDE_EN
    logic [ADDR_W-1:0] r_stride;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stride <= '0;
        end else if (w_accept) begin
            r_stride <= req_stride;
        end
    end

    assign w_step = r_stride;
`else
    assign w_step = ADDR_W'(1);
`endif

    vlsu_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (w_accept),
        .advance (w_in_access),
        .base    (req_addr),
        .step    (w_step),
        .addr    (w_gen_addr)
    );

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign w_wlanes[i]                     = r_wdata[i*LANE_W +: LANE_W];
        assign resp_rdata[i*LANE_W +: LANE_W]  = r_rlanes[i];
    end

    assign req_ready  = (r_state == IDLE);
    assign stall      = (r_state != IDLE);
    assign resp_valid = (r_state == DONE);
    assign mem_wren   = w_in_access && r_write;
    assign mem_addr   = w_in_access ? w_gen_addr : '0;
    assign mem_wdata  = mem_wren ? w_wlanes[w_wr_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_vector_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_lsu
// Description : Randomised self-checking bench for vector_lsu with a model RAM.
// Revision    : 1.0
// ============================================================================
module tb_vector_lsu;

    localparam int LANES  = 16;
    localparam int LANE_W = 8;
    localparam int ADDR_W = 16;
    localparam int VW     = LANES * LANE_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [VW-1:0]     req_wdata;
    logic [ADDR_W-1:0] req_stride;
    logic              resp_valid;
    logic [VW-1:0]     resp_rdata;
    logic              stall;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wren;
    logic [LANE_W-1:0] mem_wdata;
    logic [LANE_W-1:0] mem_rdata;

    logic [LANE_W-1:0] ram     [1<<ADDR_W];
    logic [LANE_W-1:0] ref_mem [1<<ADDR_W];
    logic [VW-1:0]     exp_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vector_lsu #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef VLSU_STRIDE_EN
        .req_stride (req_stride),
`endif
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .stall      (stall),
        .mem_addr   (mem_addr),
        .mem_wren   (mem_wren),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_wren) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] step_of(input logic [ADDR_W-1:0] st);
`ifdef VLSU_STRIDE_EN
        return st;
`else
        return ADDR_W'(1);
`endif
    endfunction

    task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [VW-1:0] wd,
                         input logic [ADDR_W-1:0] st, input bit hold);
        bit acc;
        acc = 1'b0;
        @(negedge clk);
        req_write  = wr;
        req_addr   = a;
        req_wdata  = wd;
        req_stride = st;
        req_valid  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            acc = (req_ready === 1'b1);
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        check_eq("accept", {255'd0, acc}, 256'd1);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    // Called just after the accepting edge T; samples cycles T+1 .. T+last+1.
    task automatic monitor(input logic wr, input logic [ADDR_W-1:0] a, input logic [VW-1:0] wd,
                           input logic [ADDR_W-1:0] st);
        int                last;
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] ak;
        logic [VW-1:0]     prev;
        logic [VW-1:0]     exp_new;
        last = wr ? LANES + 1 : LANES + 2;
        step = step_of(st);
        prev = exp_rdata;
        exp_new = '0;
        for (int i = 0; i < LANES; i++) begin
            ak = a + ADDR_W'(i) * step;
            exp_new[i*LANE_W +: LANE_W] = ref_mem[ak];
        end
        for (int k = 1; k <= last + 1; k++) begin
            @(negedge clk);
            check_eq("stall", {255'd0, stall}, {255'd0, (k <= last)});
            check_eq("resp_valid", {255'd0, resp_valid}, {255'd0, (k == last)});
            check_eq("req_ready", {255'd0, req_ready}, {255'd0, (k > last)});
            check_eq("mem_wren", {255'd0, mem_wren}, {255'd0, (wr && k <= LANES)});
            if (k <= LANES) begin
                ak = a + ADDR_W'(k - 1) * step;
                check_eq("mem_addr", {240'd0, mem_addr}, {240'd0, ak});
                if (wr) begin
                    check_eq("mem_wdata", {248'd0, mem_wdata}, {248'd0, wd[(k-1)*LANE_W +: LANE_W]});
                    ref_mem[ak] = wd[(k-1)*LANE_W +: LANE_W];
                end
            end
            if (k == 2) check_eq("rdata_hold", {128'd0, resp_rdata}, {128'd0, prev});
            if (k == last) check_eq("resp_rdata", {128'd0, resp_rdata}, {128'd0, wr ? prev : exp_new});
        end
        if (!wr) exp_rdata = exp_new;
    endtask

    task automatic run_op(input logic wr, input logic [ADDR_W-1:0] a, input logic [VW-1:0] wd,
                          input logic [ADDR_W-1:0] st);
        issue(wr, a, wd, st, 1'b0);
        monitor(wr, a, wd, st);
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int j = 0; j < VW / 32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] wd;
        logic [VW-1:0] seq_wd;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_stride = '0;
        exp_rdata  = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", {255'd0, req_ready}, 256'd1);
        check_eq("rst_stall", {255'd0, stall}, 256'd0);
        check_eq("rst_resp_valid", {255'd0, resp_valid}, 256'd0);
        check_eq("rst_wren", {255'd0, mem_wren}, 256'd0);
        check_eq("rst_addr", {240'd0, mem_addr}, 256'd0);
        check_eq("rst_wdata", {248'd0, mem_wdata}, 256'd0);
        check_eq("rst_rdata", {128'd0, resp_rdata}, 256'd0);
        reset = 1'b0;

        // Lane i carries i+1.
        for (int i = 0; i < LANES; i++) seq_wd[i*LANE_W +: LANE_W] = LANE_W'(i + 1);
        run_op(1'b1, 16'h0100, seq_wd, 16'd1);
        run_op(1'b0, 16'h0100, '0, 16'd1);
        check_eq("load_0100", {128'd0, resp_rdata}, {128'd0, seq_wd});

        // Wrap across the top of the address space.
        run_op(1'b1, 16'hFFF8, rand_vec(), 16'd1);
        run_op(1'b0, 16'hFFF8, '0, 16'd1);

`ifdef VLSU_STRIDE_EN
        run_op(1'b1, 16'h0000, rand_vec(), 16'd4);
        run_op(1'b0, 16'h0000, '0, 16'd4);
        run_op(1'b1, 16'h0040, rand_vec(), 16'd0);
        run_op(1'b0, 16'h0040, '0, 16'd0);
`else
        run_op(1'b1, 16'h0000, rand_vec(), 16'd1);
`endif

        // Abort a store with reset at the start of cycle T+5.
        wd = rand_vec();
        issue(1'b1, 16'h0200, wd, 16'd1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_eq("abort_wren", {255'd0, mem_wren}, 256'd1);
            check_eq("abort_addr", {240'd0, mem_addr}, {240'd0, 16'h0200 + 16'(k - 1)});
            ref_mem[16'h0200 + 16'(k - 1)] = wd[(k-1)*LANE_W +: LANE_W];
        end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_eq("abort_wren_off", {255'd0, mem_wren}, 256'd0);
        check_eq("abort_stall", {255'd0, stall}, 256'd0);
        check_eq("abort_ready", {255'd0, req_ready}, 256'd1);
        check_eq("abort_resp", {255'd0, resp_valid}, 256'd0);
        check_eq("abort_mem_addr", {240'd0, mem_addr}, 256'd0);
        check_eq("abort_rdata", {128'd0, resp_rdata}, 256'd0);
        exp_rdata = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_eq("abort_ram", {248'd0, ram[16'h0200 + 16'(i)]}, {248'd0, ref_mem[16'h0200 + 16'(i)]});
        end
        run_op(1'b1, 16'h0300, rand_vec(), 16'd1);

        // Back-to-back loads with req_valid held; request changes mid-operation.
        issue(1'b0, 16'h0100, '0, 16'd1, 1'b1);
        req_addr = 16'h0200;
        monitor(1'b0, 16'h0100, '0, 16'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        monitor(1'b0, 16'h0200, '0, 16'd1);

        for (int n = 0; n < 12; n++) begin
            run_op(1'($urandom_range(0, 1)), 16'($urandom), rand_vec(), 16'($urandom_range(0, 8)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
